dbg_event_writer: RTL and testbench
===================================

DBG_EVENT_WRITER -- requirements
Module: dbg_event_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event FIFO entries; power of two, at least 2.
REQ-002 Port clk_i  input  1  clock, all state on rising edge.
REQ-003 Port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 Port evt_valid_i  input  1  event producer has a record.
REQ-005 Port evt_ready_o  output  1  block accepts a record this cycle.
REQ-006 Port evt_kind_i  input  4  event kind, encoded per dbg_evt_pkg.
REQ-007 Port evt_data_i  input  32  event payload.
REQ-008 Port en_o  output  1  debug bus access request.
REQ-009 Port we_o  output  1  write strobe; equals en_o.
REQ-010 Port addr_o  output  24  debug bus address.
REQ-011 Port data_o  output  32  debug bus write data.
REQ-012 Port gnt_i  input  1  bus completes the presented write this cycle.
REQ-013 Port drop_cnt_o  output  16  count of records with invalid kind.
REQ-014 Port halted_o  output  1  HALT write completed.
REQ-015 Port busy_o  output  1  FIFO non-empty or write pending.

Function
REQ-016 Handshake: record pushed on the rising edge where evt_valid_i && evt_ready_o.
REQ-017 evt_ready_o = !full && !halted_o, registered; no same-cycle pop-to-push bypass when full.
REQ-018 Kind map: 0 UART_CHAR->0x000000; 1 HALT->0x000004; 2 SCHED->0x000010; 3 PIPE_ADD->0x000020; 4 PIPE_REM->0x000024; 5 REQ_ADD->0x000030; 6 REQ_REM->0x000034; 7 AV_ADD->0x000040; 8 AV_REM->0x000044; 9 UART_WORD; 10-15 invalid.
REQ-019 Single-write kinds: data_o = evt_data_i unmodified; UART_CHAR data_o = {24'h0, data[7:0]}.
REQ-020 Latency: record accepted into empty FIFO at edge N -> en_o high in cycle after edge N+1; minimum 1 cycle.
REQ-021 While en_o && !gnt_i: en_o, addr_o, data_o held stable.
REQ-022 On gnt_i the next write is presented the following cycle with no bubble if available.
REQ-023 FSM states IDLE, ISSUE, UART_BYTES, HALTED.
REQ-024 IDLE->ISSUE when FIFO non-empty and head kind valid and not UART_WORD; IDLE->UART_BYTES for UART_WORD; ISSUE->IDLE/next on gnt_i; ISSUE->HALTED on gnt_i of a HALT write.
REQ-025 UART_WORD: bytes [7:0],[15:8],[23:16],[31:24] issued in order, each a write to 0x000000 zero-extended; sequence ends before the first 0x00 byte or after byte 3.
REQ-026 UART_WORD with byte 0 = 0x00: entry consumed, zero bus writes.
REQ-027 Invalid kind: entry consumed in one cycle, no bus activity, drop_cnt_o += 1, saturating at 0xFFFF.
REQ-028 HALTED: en_o=0, evt_ready_o=0, remaining FIFO entries retained and never issued; exit only by reset.
REQ-029 busy_o = FIFO non-empty || en_o; in HALTED, busy_o reflects FIFO only.

Reset
REQ-030 rst_ni low: en_o=0, we_o=0, addr_o=0, data_o=0, evt_ready_o=0, drop_cnt_o=0, halted_o=0, busy_o=0, FIFO empty, state IDLE, immediately and asynchronously.
REQ-031 evt_ready_o rises on the first clock edge after reset release.
REQ-032 Reset during a pending write or UART_WORD sequence aborts it; no partial state survives.

Structure
REQ-033 Package dbg_evt_pkg holds the kind enum, address constants, and the FIFO record typedef (kind, data).
REQ-034 One sub-module dbg_evt_fifo: synchronous FIFO_DEPTH-entry FIFO with full/empty flags and wrap-around pointers.

Verification
REQ-035 Push UART_CHAR data 0x41, gnt_i=1 -> one write addr 0x000000 data 0x00000041, one cycle after acceptance.
REQ-036 Push SCHED 0x00030005 with gnt_i low 5 cycles -> en_o/addr 0x10/data stable 5 cycles, single write on grant.
REQ-037 Push UART_WORD 0x00636261 -> three writes at 0x0 with data 0x61,0x62,0x63, then idle.
REQ-038 Push 9 records, gnt_i=0, FIFO_DEPTH=8 -> evt_ready_o low after 8 accepted (first already presented), no loss; release gnt_i -> all 9 issued in order.
REQ-039 Push kind 12 ×3, then PIPE_ADD 0x00010002 -> drop_cnt_o=3, one write at 0x20 data 0x00010002.
REQ-040 Push HALT then AV_ADD -> write at 0x4, halted_o=1, no write at 0x40, evt_ready_o=0; assert rst_ni mid-wait -> all outputs zero immediately.

Source files
------------

// File: rtl/dbg_evt_pkg.sv
// Shared types and constants for the debug event writer: event kinds,
// debug-bus register addresses and the FIFO record layout.
package dbg_evt_pkg;

  localparam int unsigned KIND_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 24;

  typedef enum logic [KIND_W-1:0] {
    KIND_UART_CHAR = 4'd0,
    KIND_HALT      = 4'd1,
    KIND_SCHED     = 4'd2,
    KIND_PIPE_ADD  = 4'd3,
    KIND_PIPE_REM  = 4'd4,
    KIND_REQ_ADD   = 4'd5,
    KIND_REQ_REM   = 4'd6,
    KIND_AV_ADD    = 4'd7,
    KIND_AV_REM    = 4'd8,
    KIND_UART_WORD = 4'd9
  } evt_kind_e;

  localparam logic [ADDR_W-1:0] ADDR_UART     = 24'h000000;
  localparam logic [ADDR_W-1:0] ADDR_HALT     = 24'h000004;
  localparam logic [ADDR_W-1:0] ADDR_SCHED    = 24'h000010;
  localparam logic [ADDR_W-1:0] ADDR_PIPE_ADD = 24'h000020;
  localparam logic [ADDR_W-1:0] ADDR_PIPE_REM = 24'h000024;
  localparam logic [ADDR_W-1:0] ADDR_REQ_ADD  = 24'h000030;
  localparam logic [ADDR_W-1:0] ADDR_REQ_REM  = 24'h000034;
  localparam logic [ADDR_W-1:0] ADDR_AV_ADD   = 24'h000040;
  localparam logic [ADDR_W-1:0] ADDR_AV_REM   = 24'h000044;

  typedef struct packed {
    logic [KIND_W-1:0] kind;
    logic [DATA_W-1:0] data;
  } evt_rec_t;

  function automatic logic kind_valid(input logic [KIND_W-1:0] k);
    return k <= KIND_W'(KIND_UART_WORD);
  endfunction

  function automatic logic [ADDR_W-1:0] kind_addr(input logic [KIND_W-1:0] k);
    case (k)
      KIND_W'(KIND_HALT):     return ADDR_HALT;
      KIND_W'(KIND_SCHED):    return ADDR_SCHED;
      KIND_W'(KIND_PIPE_ADD): return ADDR_PIPE_ADD;
      KIND_W'(KIND_PIPE_REM): return ADDR_PIPE_REM;
      KIND_W'(KIND_REQ_ADD):  return ADDR_REQ_ADD;
      KIND_W'(KIND_REQ_REM):  return ADDR_REQ_REM;
      KIND_W'(KIND_AV_ADD):   return ADDR_AV_ADD;
      KIND_W'(KIND_AV_REM):   return ADDR_AV_REM;
      default:                return ADDR_UART;
    endcase
  endfunction

endpackage

// File: rtl/dbg_evt_fifo.sv
// Synchronous event-record FIFO; pointers wrap naturally (DEPTH is a power of two).
module dbg_evt_fifo
  import dbg_evt_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push,
  input  evt_rec_t               wr_data,
  input  logic                   pop,
  output evt_rec_t               rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  evt_rec_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    rd_data = mem[rd_ptr];
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/dbg_event_writer.sv
// Drains buffered debug events onto the debug bus as register writes;
// UART_WORD expands to up to four byte writes, HALT freezes the writer.
module dbg_event_writer
  import dbg_evt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        evt_valid_i,
  output logic        evt_ready_o,
  input  logic [3:0]  evt_kind_i,
  input  logic [31:0] evt_data_i,
  output logic        en_o,
  output logic        we_o,
  output logic [23:0] addr_o,
  output logic [31:0] data_o,
  input  logic        gnt_i,
  output logic [15:0] drop_cnt_o,
  output logic        halted_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, UART_BYTES, HALTED} state_e;

  state_e           state;
  logic             is_halt;
  logic [23:0]      rest;
  logic [1:0]       rem;
  evt_rec_t         head;
  evt_rec_t         wr_rec;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             push;
  logic             pop;
  logic             halt_done;
  logic             next_byte;
  logic             seq_end;
  logic             en_nxt;
  logic             halted_nxt;

  dbg_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (push),
    .wr_data (wr_rec),
    .pop     (pop),
    .rd_data (head),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  // seq_end marks cycles where the next FIFO entry may be dispatched (no bubble after a grant).
  always_comb begin
    wr_rec     = '{kind: evt_kind_i, data: evt_data_i};
    push       = evt_valid_i && evt_ready_o;
    halt_done  = (state == ISSUE) && gnt_i && is_halt;
    next_byte  = (state == UART_BYTES) && gnt_i && (rem != 2'd0) && (rest[7:0] != 8'h00);
    seq_end    = (state == IDLE) || ((state == ISSUE) && gnt_i && !is_halt) ||
                 ((state == UART_BYTES) && gnt_i && !next_byte);
    pop        = seq_end && !empty;
    count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
    halted_nxt = halted_o || halt_done;
    en_nxt     = en_o;
    if (halt_done) begin
      en_nxt = 1'b0;
    end else if (next_byte) begin
      en_nxt = 1'b1;
    end else if (seq_end) begin
      en_nxt = pop && kind_valid(head.kind) &&
               !((head.kind == 4'(KIND_UART_WORD)) && (head.data[7:0] == 8'h00));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      is_halt     <= 1'b0;
      rest        <= '0;
      rem         <= '0;
      evt_ready_o <= 1'b0;
      en_o        <= 1'b0;
      we_o        <= 1'b0;
      addr_o      <= '0;
      data_o      <= '0;
      drop_cnt_o  <= '0;
      halted_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      evt_ready_o <= (count_nxt != CNT_W'(FIFO_DEPTH)) && !halted_nxt;
      busy_o      <= (count_nxt != '0) || en_nxt;
      en_o        <= en_nxt;
      we_o        <= en_nxt;
      if (halt_done) begin
        state    <= HALTED;
        halted_o <= 1'b1;
      end else if (next_byte) begin
        data_o <= {24'h0, rest[7:0]};
        rest   <= {8'h00, rest[23:8]};
        rem    <= rem - 2'd1;
      end else if (seq_end) begin
        if (!pop) begin
          state <= IDLE;
        end else if (!kind_valid(head.kind)) begin
          state <= IDLE;
          if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
        end else if (head.kind == 4'(KIND_UART_WORD)) begin
          addr_o <= ADDR_UART;
          data_o <= {24'h0, head.data[7:0]};
          rest   <= head.data[31:8];
          rem    <= 2'd3;
          state  <= (head.data[7:0] == 8'h00) ? IDLE : UART_BYTES;
        end else begin
          addr_o  <= kind_addr(head.kind);
          data_o  <= (head.kind == 4'(KIND_UART_CHAR)) ? {24'h0, head.data[7:0]} : head.data;
          is_halt <= (head.kind == 4'(KIND_HALT));
          state   <= ISSUE;
        end
      end
    end
  end

endmodule

// File: tb/tb_dbg_event_writer.sv
// Directed bench for dbg_event_writer: kind-map vector table plus
// hand-written stall, UART_WORD, overflow, drop and HALT/reset sequences.
module tb_dbg_event_writer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        evt_valid_i;
  logic        evt_ready_o;
  logic [3:0]  evt_kind_i;
  logic [31:0] evt_data_i;
  logic        en_o;
  logic        we_o;
  logic [23:0] addr_o;
  logic [31:0] data_o;
  logic        gnt_i;
  logic [15:0] drop_cnt_o;
  logic        halted_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_drop = 16'd0;

  typedef struct {
    logic [3:0]  kind;
    logic [31:0] data;
    logic        exp_en;
    logic [23:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_drop;
  } vec_t;

  vec_t vecs[12];

  dbg_event_writer #(.FIFO_DEPTH(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .evt_valid_i (evt_valid_i),
    .evt_ready_o (evt_ready_o),
    .evt_kind_i  (evt_kind_i),
    .evt_data_i  (evt_data_i),
    .en_o        (en_o),
    .we_o        (we_o),
    .addr_o      (addr_o),
    .data_o      (data_o),
    .gnt_i       (gnt_i),
    .drop_cnt_o  (drop_cnt_o),
    .halted_o    (halted_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    chk("wait_idle", 32'(busy_o), 32'd0);
  endtask

  task automatic push_one(input logic [3:0] k, input logic [31:0] d);
    evt_valid_i = 1'b1;
    evt_kind_i  = k;
    evt_data_i  = d;
    step();
    evt_valid_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},    32'(en_o),        32'd0);
    chk({tag, "_we"},    32'(we_o),        32'd0);
    chk({tag, "_addr"},  32'(addr_o),      32'd0);
    chk({tag, "_data"},  data_o,           32'd0);
    chk({tag, "_ready"}, 32'(evt_ready_o), 32'd0);
    chk({tag, "_drop"},  32'(drop_cnt_o),  32'd0);
    chk({tag, "_halt"},  32'(halted_o),    32'd0);
    chk({tag, "_busy"},  32'(busy_o),      32'd0);
  endtask

  initial begin
    logic [31:0] recs[9];
    int idx;
    int cyc;
    int n;
    logic acc;

    vecs[0]  = '{4'd0,  32'hAABBCC41, 1'b1, 24'h000000, 32'h00000041, 1'b0};
    vecs[1]  = '{4'd2,  32'h12345678, 1'b1, 24'h000010, 32'h12345678, 1'b0};
    vecs[2]  = '{4'd3,  32'h00000003, 1'b1, 24'h000020, 32'h00000003, 1'b0};
    vecs[3]  = '{4'd4,  32'hFFFFFFFF, 1'b1, 24'h000024, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{4'd5,  32'h00A5005A, 1'b1, 24'h000030, 32'h00A5005A, 1'b0};
    vecs[5]  = '{4'd6,  32'h80000001, 1'b1, 24'h000034, 32'h80000001, 1'b0};
    vecs[6]  = '{4'd7,  32'hCAFEBABE, 1'b1, 24'h000040, 32'hCAFEBABE, 1'b0};
    vecs[7]  = '{4'd8,  32'h0BADF00D, 1'b1, 24'h000044, 32'h0BADF00D, 1'b0};
    vecs[8]  = '{4'd9,  32'h00000041, 1'b1, 24'h000000, 32'h00000041, 1'b0};
    vecs[9]  = '{4'd9,  32'h44332200, 1'b0, 24'h000000, 32'h00000000, 1'b0};
    vecs[10] = '{4'd10, 32'h11111111, 1'b0, 24'h000000, 32'h00000000, 1'b1};
    vecs[11] = '{4'd15, 32'h22222222, 1'b0, 24'h000000, 32'h00000000, 1'b1};

    rst_ni = 1'b0;
    evt_valid_i = 1'b0;
    evt_kind_i = 4'd0;
    evt_data_i = 32'd0;
    gnt_i = 1'b0;
    #3;
    chk_all_zero("reset");
    #10;
    rst_ni = 1'b1;
    step();
    chk("ready_after_reset", 32'(evt_ready_o), 32'd1);

    // Kind map table with immediate grant.
    gnt_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wait_idle();
      chk($sformatf("v%0d_ready", i), 32'(evt_ready_o), 32'd1);
      push_one(vecs[i].kind, vecs[i].data);
      step();
      if (vecs[i].exp_drop) exp_drop = exp_drop + 16'd1;
      chk($sformatf("v%0d_en", i), 32'(en_o), 32'(vecs[i].exp_en));
      chk($sformatf("v%0d_we", i), 32'(we_o), 32'(vecs[i].exp_en));
      if (vecs[i].exp_en) begin
        chk($sformatf("v%0d_addr", i), 32'(addr_o), 32'(vecs[i].exp_addr));
        chk($sformatf("v%0d_data", i), data_o, vecs[i].exp_data);
      end
      chk($sformatf("v%0d_drop", i), 32'(drop_cnt_o), 32'(exp_drop));
      step();
      chk($sformatf("v%0d_single", i), 32'(en_o), 32'd0);
    end

    // SCHED held for 5 cycles without grant.
    wait_idle();
    gnt_i = 1'b0;
    push_one(4'd2, 32'h00030005);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("stall%0d_en", c), 32'(en_o), 32'd1);
      chk($sformatf("stall%0d_addr", c), 32'(addr_o), 32'h10);
      chk($sformatf("stall%0d_data", c), data_o, 32'h00030005);
    end
    gnt_i = 1'b1;
    step();
    chk("stall_done_en", 32'(en_o), 32'd0);

    // UART_WORD ending before a zero byte.
    wait_idle();
    push_one(4'd9, 32'h00636261);
    for (int b = 0; b < 3; b++) begin
      step();
      chk($sformatf("uw%0d_en", b), 32'(en_o), 32'd1);
      chk($sformatf("uw%0d_addr", b), 32'(addr_o), 32'h0);
      chk($sformatf("uw%0d_data", b), data_o, 32'h61 + 32'(b));
    end
    step();
    chk("uw_end_en", 32'(en_o), 32'd0);

    // Three invalid kinds then PIPE_ADD, back to back.
    wait_idle();
    for (int k = 0; k < 3; k++) push_one(4'd12, 32'hDEAD0000 + 32'(k));
    push_one(4'd3, 32'h00010002);
    exp_drop = exp_drop + 16'd3;
    n = 0;
    while (en_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("drop_wr_en", 32'(en_o), 32'd1);
    chk("drop_wr_addr", 32'(addr_o), 32'h20);
    chk("drop_wr_data", data_o, 32'h00010002);
    chk("drop_cnt", 32'(drop_cnt_o), 32'(exp_drop));
    step();
    chk("drop_wr_single", 32'(en_o), 32'd0);

    // Overflow: one record presented plus eight buffered before ready drops.
    wait_idle();
    gnt_i = 1'b0;
    for (int r = 0; r < 9; r++) recs[r] = 32'h00000100 + 32'(r);
    idx = 0;
    cyc = 0;
    while (idx < 9 && cyc < 40) begin
      evt_valid_i = 1'b1;
      evt_kind_i  = 4'd3;
      evt_data_i  = recs[idx];
      acc = evt_ready_o;
      step();
      if (acc) idx++;
      cyc++;
    end
    evt_valid_i = 1'b0;
    chk("ovf_accepted", 32'(idx), 32'd9);
    chk("ovf_cycles", 32'(cyc), 32'd9);
    chk("ovf_ready_low", 32'(evt_ready_o), 32'd0);
    chk("ovf_busy", 32'(busy_o), 32'd1);
    gnt_i = 1'b1;
    for (int r = 0; r < 9; r++) begin
      chk($sformatf("ovf%0d_en", r), 32'(en_o), 32'd1);
      chk($sformatf("ovf%0d_addr", r), 32'(addr_o), 32'h20);
      chk($sformatf("ovf%0d_data", r), data_o, recs[r]);
      step();
    end
    chk("ovf_end_en", 32'(en_o), 32'd0);
    chk("ovf_end_busy", 32'(busy_o), 32'd0);
    chk("ovf_end_ready", 32'(evt_ready_o), 32'd1);

    // Reset aborts a pending write.
    gnt_i = 1'b0;
    push_one(4'd2, 32'h5A5A5A5A);
    step();
    chk("abort_pre_en", 32'(en_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    exp_drop = 16'd0;
    #1;
    chk("abort_en", 32'(en_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    #4;
    rst_ni = 1'b1;
    step();
    step();
    chk("abort_after_en", 32'(en_o), 32'd0);
    chk("abort_after_busy", 32'(busy_o), 32'd0);

    // HALT then AV_ADD; AV_ADD retained but never issued.
    push_one(4'd1, 32'h00000001);
    push_one(4'd7, 32'h0000DEAD);
    chk("halt_en", 32'(en_o), 32'd1);
    chk("halt_addr", 32'(addr_o), 32'h4);
    gnt_i = 1'b1;
    step();
    chk("halted", 32'(halted_o), 32'd1);
    chk("halted_en", 32'(en_o), 32'd0);
    chk("halted_ready", 32'(evt_ready_o), 32'd0);
    chk("halted_busy", 32'(busy_o), 32'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("halted%0d_en", c), 32'(en_o), 32'd0);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    chk_all_zero("halt_reset");
    #4;
    rst_ni = 1'b1;
    step();
    chk("post_halt_ready", 32'(evt_ready_o), 32'd1);
    chk("post_halt_busy", 32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
